// File: rtl/wish_arb_pkg.sv
// Shared types and width helpers for the wish_rr_arb round-robin stream arbiter.
package wish_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Index width for an n-entry selector; at least one bit so a 1-entry case still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One extra bit so the beat counter can represent BURST_LEN-1 for any BURST_LEN.
    function automatic int cnt_width(input int burst);
        return $clog2(burst) + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_i scanning upward from last_i+1, wrapping.
module rr_pick
    import wish_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    int k;

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        for (int i = N; i >= 1; i--) begin
            k = (int'(last_i) + i) % N;
            if (req_i[k]) begin
                valid_o = 1'b1;
                idx_o   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/wish_rr_arb.sv
// Round-robin arbiter sharing one pipelined Wishbone-style stream sink between NUM_SRC sources.
// Optional watchdog (timeout_o port) enabled by defining WISH_RR_ARB_TIMEOUT_EN.
module wish_rr_arb
    import wish_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TGC_WIDTH  = 2,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [NUM_SRC-1:0]              s_cyc_i,
    input  logic [NUM_SRC-1:0]              s_stb_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_dat_i,
    input  logic [NUM_SRC*TGC_WIDTH-1:0]    s_tgc_i,
    output logic [NUM_SRC-1:0]              s_ack_o,
    output logic [NUM_SRC-1:0]              s_stall_o,
    output logic                            d_cyc_o,
    output logic                            d_stb_o,
    output logic [DATA_WIDTH-1:0]           d_dat_o,
    output logic [TGC_WIDTH-1:0]            d_tgc_o,
    input  logic                            d_ack_i,
    input  logic                            d_stall_i,
    output logic [idx_width(NUM_SRC)-1:0]   grant_o,
`ifdef WISH_RR_ARB_TIMEOUT_EN
    output logic                            timeout_o,
`endif
    output logic                            busy_o
);

    localparam int IW = idx_width(NUM_SRC);
    localparam int CW = cnt_width(BURST_LEN);

    if (NUM_SRC < 2 || BURST_LEN < 1 || TIMEOUT < 1) begin : g_param_check
        $error("wish_rr_arb: NUM_SRC must be >= 2, BURST_LEN and TIMEOUT >= 1");
    end

    // Handshake: a beat moves when the source holds cyc&stb; stall means "not taken this
    // cycle, hold the beat"; ack marks one accepted beat and only ever reaches the granted source.

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q,  last_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          busy;
    logic          g_cyc;
    logic          g_ack;
    logic          last_beat;
    logic          timeout_hit;
    logic          exit_grant;

    rr_pick #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_pick (
        .req_i   (s_cyc_i),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef WISH_RR_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    // Counter sits at zero in IDLE, so GRANT entry always starts from a cleared watchdog.
    always_comb begin
        wd_d        = '0;
        timeout_hit = 1'b0;
        if (busy) begin
            timeout_hit = !g_ack && (wd_q == WD_W'(TIMEOUT - 1));
            if (!g_ack && !exit_grant && !timeout_hit) begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout_o = timeout_hit;
`else
    assign timeout_hit = 1'b0;
`endif

    assign busy      = (state_q == ARB_GRANT);
    assign g_cyc     = s_cyc_i[grant_q];
    assign g_ack     = busy && d_ack_i && g_cyc;
    assign last_beat = (cnt_q == CW'(BURST_LEN - 1));
    // An ack coinciding with a dropped cyc is never forwarded, so it exits through the abort term.
    assign exit_grant = busy && ((g_ack && last_beat) || !g_cyc || timeout_hit);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d = ARB_GRANT;
                    grant_d = pick_idx;
                end
            end
            ARB_GRANT: begin
                if (exit_grant) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                    cnt_d   = '0;
                end else if (g_ack) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_SRC - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sink side follows the granted source combinationally, so an abort drops d_cyc_o at once.
    always_comb begin
        d_cyc_o   = 1'b0;
        d_stb_o   = 1'b0;
        d_dat_o   = '0;
        d_tgc_o   = '0;
        s_ack_o   = '0;
        s_stall_o = '1;
        if (busy) begin
            d_cyc_o            = g_cyc;
            d_stb_o            = g_cyc && s_stb_i[grant_q];
            d_dat_o            = s_dat_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            d_tgc_o            = s_tgc_i[int'(grant_q)*TGC_WIDTH +: TGC_WIDTH];
            s_ack_o[grant_q]   = d_ack_i && g_cyc;
            s_stall_o[grant_q] = d_stall_i;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy;

endmodule

// File: tb/tb_wish_rr_arb.sv
// Randomized bench for wish_rr_arb: a round-robin reference model predicts the accepted beat stream.
module tb_wish_rr_arb;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TW  = 2;
    localparam int BL  = 4;
    localparam int IW  = 2;
    localparam int W   = IW + DW + TW;
    localparam int MAXB = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    s_cyc_i = '0;
    logic [N-1:0]    s_stb_i = '0;
    logic [N*DW-1:0] s_dat_i = '0;
    logic [N*TW-1:0] s_tgc_i = '0;
    logic [N-1:0]    s_ack_o;
    logic [N-1:0]    s_stall_o;
    logic            d_cyc_o;
    logic            d_stb_o;
    logic [DW-1:0]   d_dat_o;
    logic [TW-1:0]   d_tgc_o;
    logic            d_ack_i = 1'b0;
    logic            d_stall_i = 1'b0;
    logic [IW-1:0]   grant_o;
    logic            busy_o;
`ifdef WISH_RR_ARB_TIMEOUT_EN
    logic            timeout_o;
`endif

    always #5 clk = ~clk;

    wish_rr_arb #(
        .NUM_SRC    (N),
        .DATA_WIDTH (DW),
        .TGC_WIDTH  (TW),
        .BURST_LEN  (BL),
        .TIMEOUT    (16)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .s_cyc_i   (s_cyc_i),
        .s_stb_i   (s_stb_i),
        .s_dat_i   (s_dat_i),
        .s_tgc_i   (s_tgc_i),
        .s_ack_o   (s_ack_o),
        .s_stall_o (s_stall_o),
        .d_cyc_o   (d_cyc_o),
        .d_stb_o   (d_stb_o),
        .d_dat_o   (d_dat_o),
        .d_tgc_o   (d_tgc_o),
        .d_ack_i   (d_ack_i),
        .d_stall_i (d_stall_i),
        .grant_o   (grant_o),
`ifdef WISH_RR_ARB_TIMEOUT_EN
        .timeout_o (timeout_o),
`endif
        .busy_o    (busy_o)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [W-1:0]  exp_q[$];
    int            pend[N];
    int            bcnt[N];
    logic [DW-1:0] dat_tab[N][MAXB];
    logic [TW-1:0] tgc_tab[N][MAXB];
    logic [N-1:0]  ack_seen = '0;
    int            model_last = N - 1;
    int            force_stall = 0;
    logic          prev_busy = 1'b0;
    logic [IW-1:0] prev_grant = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_srcs();
        for (int k = 0; k < N; k++) begin
            s_cyc_i[k] = (pend[k] > 0);
            s_stb_i[k] = (pend[k] > 0);
            if (bcnt[k] < MAXB) begin
                s_dat_i[k*DW +: DW] = dat_tab[k][bcnt[k]];
                s_tgc_i[k*TW +: TW] = tgc_tab[k][bcnt[k]];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (ack_seen[k] && pend[k] > 0) begin
                pend[k]--;
                bcnt[k]++;
            end
        end
        drive_srcs();
        if (force_stall > 0) begin
            d_ack_i   = 1'b0;
            d_stall_i = 1'b1;
            force_stall--;
        end else begin
            d_ack_i   = ($urandom_range(0, 9) < 7);
            d_stall_i = !d_ack_i;
        end
    endtask

    function automatic bit any_pend();
        for (int k = 0; k < N; k++) if (pend[k] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: every source holding a request is served in rotation after the last server,
    // taking up to BL beats per turn; a turn shorter than BL is an abort that still moves the pointer.
    task automatic setup_phase();
        int rem[N];
        int off[N];
        int take;
        int nxt;
        for (int k = 0; k < N; k++) begin
            bcnt[k] = 0;
            rem[k]  = pend[k];
            off[k]  = 0;
            for (int b = 0; b < MAXB; b++) begin
                dat_tab[k][b] = DW'($urandom);
                tgc_tab[k][b] = TW'($urandom);
            end
        end
        while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
            nxt = -1;
            for (int i = N; i >= 1; i--) begin
                if (rem[(model_last + i) % N] > 0) nxt = (model_last + i) % N;
            end
            take = (rem[nxt] < BL) ? rem[nxt] : BL;
            for (int b = 0; b < take; b++) begin
                exp_q.push_back({IW'(nxt), dat_tab[nxt][off[nxt] + b], tgc_tab[nxt][off[nxt] + b]});
            end
            off[nxt]   += take;
            rem[nxt]   -= take;
            model_last  = nxt;
        end
        drive_srcs();
    endtask

    task automatic finish_phase(input string name);
        int guard = 0;
        while (any_pend() && guard < 600) begin
            step();
            guard++;
        end
        check({name, "_timeout"}, 32'(guard < 600), 32'd1);
        step();
        step();
        check({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        for (int k = 0; k < N; k++) pend[k] = 0;
        drive_srcs();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        int           ai;
        ack_seen = s_ack_o;
        check("ack_onehot", 32'($onehot0(s_ack_o)), 32'd1);
        check("ack_and_stall", 32'(s_ack_o & s_stall_o), 32'd0);
        if (!busy_o) begin
            check("idle_sink", {d_cyc_o, d_stb_o, d_dat_o, d_tgc_o}, '0);
            check("idle_src", {s_ack_o, s_stall_o}, {{N{1'b0}}, {N{1'b1}}});
        end else begin
            check("d_cyc_route", 32'(d_cyc_o), 32'(s_cyc_i[grant_o]));
            check("d_stb_route", 32'(d_stb_o), 32'(s_cyc_i[grant_o] & s_stb_i[grant_o]));
            check("stall_granted", 32'(s_stall_o[grant_o]), 32'(d_stall_i));
            for (int k = 0; k < N; k++) begin
                if (k != int'(grant_o)) check("stall_other", 32'(s_stall_o[k]), 32'd1);
            end
            if (prev_busy) check("grant_stable", 32'(grant_o), 32'(prev_grant));
        end
        if (|s_ack_o) begin
            ai = 0;
            for (int k = 0; k < N; k++) if (s_ack_o[k]) ai = k;
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 32'(s_ack_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat", 32'({IW'(ai), d_dat_o, d_tgc_o}), 32'(e));
                check("beat_grant", 32'(grant_o), 32'(e[W-1 -: IW]));
            end
        end
        prev_busy  = busy_o;
        prev_grant = grant_o;
    end

    // ---------------- clock/reset and test sequence ----------------
    initial begin
        for (int k = 0; k < N; k++) begin
            pend[k] = 0;
            bcnt[k] = 0;
        end
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_stall", 32'(s_stall_o), 32'({N{1'b1}}));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // All sources with two bursts each: 0,1,2,3,0,1,2,3.
        for (int k = 0; k < N; k++) pend[k] = 2 * BL;
        setup_phase();
        finish_phase("all_rr");

        // Lone requester src1 with one full burst.
        pend[1] = BL;
        setup_phase();
        finish_phase("single_src1");

        // src2 stalled for three cycles mid-burst.
        pend[2] = BL;
        setup_phase();
        for (int i = 0; i < 200 && bcnt[2] < 2; i++) step();
        force_stall = 3;
        finish_phase("stall_src2");

        // Aborts: src0 quits after 2 beats, src1 aborts on its second turn.
        pend[0] = 2;
        pend[1] = BL + 1;
        pend[3] = BL;
        setup_phase();
        finish_phase("abort");

        // Reset in the middle of a burst, then src0 must win first.
        pend[1] = 2 * BL;
        pend[2] = 2 * BL;
        setup_phase();
        for (int i = 0; i < 200 && (bcnt[1] + bcnt[2]) < 2; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_dcyc", 32'(d_cyc_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_ack", 32'(s_ack_o), 32'd0);
        exp_q.delete();
        for (int k = 0; k < N; k++) pend[k] = 0;
        model_last = N - 1;
        drive_srcs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) pend[k] = BL;
        setup_phase();
        finish_phase("after_rst");

        // Random request mixes, including multi-turn and aborting sources.
        for (int p = 0; p < 25; p++) begin
            for (int k = 0; k < N; k++) begin
                pend[k] = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 10);
            end
            if (!any_pend()) pend[$urandom_range(0, N - 1)] = $urandom_range(1, 10);
            setup_phase();
            finish_phase("random");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
